// File: rtl/cdc_hs_pkg.sv
// Shared types and constants for the two-phase toggle CDC handshake.
// Used by both the source (cdc_hs_src) and destination ends.
package cdc_hs_pkg;

    typedef enum logic {
        HS_IDLE = 1'b0,
        HS_BUSY = 1'b1
    } hs_state_e;

    localparam int HS_STAGE_MIN = 2;
    localparam int HS_STAGE_MAX = 4;

    // Keeps a synchroniser depth inside the supported range.
    function automatic int hs_stage_clamp(input int stage);
        if (stage < HS_STAGE_MIN) return HS_STAGE_MIN;
        if (stage > HS_STAGE_MAX) return HS_STAGE_MAX;
        return stage;
    endfunction

endpackage

// File: rtl/cdc_hs_ack_sync.sv
// Single-bit, STAGE-deep synchroniser for the returned acknowledge toggle.
// quiet_o reports that every stage holds the same value, so ack_s is settled.
module cdc_hs_ack_sync
    import cdc_hs_pkg::*;
#(
    parameter int STAGE = 2
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic q_o,
    output logic quiet_o
);

    localparam int N = hs_stage_clamp(STAGE);

    logic [N-1:0] r_sync;

    always_ff @(posedge clk_i) begin
        // NOTE: reset is sampled inside the clocked block and all state uses <=.
        if (!rst_n_i) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[N-2:0], d_i};
        end
    end

    assign q_o     = r_sync[N-1];
    assign quiet_o = (&r_sync) || !(|r_sync);

endmodule

// File: rtl/cdc_hs_src.sv
// Launching end of a two-phase toggle req/ack CDC handshake (source clock domain).
// Define CDC_HS_SRC_BUF_EN to add a one-entry pending buffer for gap-free launches.
module cdc_hs_src
    import cdc_hs_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int STAGE      = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  valid_i,
    input  logic [DATA_WIDTH-1:0] dat_i,
    output logic                  ready_o,
    output logic                  req_o,
    output logic [DATA_WIDTH-1:0] dat_o,
    input  logic                  ack_i,
    output logic                  busy_o,
    output logic                  done_o
);

    logic                  r_req;
    logic [DATA_WIDTH-1:0] r_dat;
    logic                  r_pending;
    logic                  r_live;
    logic                  w_ack_s;
    logic                  w_quiet;
    logic                  w_accept;
    logic                  w_launch_ok;
    logic                  w_done;
    hs_state_e             w_state;

    cdc_hs_ack_sync #(.STAGE(STAGE)) u_ack_sync (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .d_i     (ack_i),
        .q_o     (w_ack_s),
        .quiet_o (w_quiet)
    );

    assign w_state = (w_ack_s == r_req) ? HS_IDLE : HS_BUSY;

    // A launch needs the synchroniser to have sampled ack_i since reset and to be
    // settled, so a stuck-high ack from an unreset destination is seen first.
    assign w_launch_ok = (w_state == HS_IDLE) && r_live && w_quiet;
    assign w_done      = r_pending && (w_state == HS_IDLE);
    assign w_accept    = valid_i && ready_o;

`ifdef CDC_HS_SRC_BUF_EN
    logic                  r_pend_vld;
    logic [DATA_WIDTH-1:0] r_pend_dat;

    assign ready_o = !r_pend_vld && rst_n_i;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_req      <= 1'b0;
            r_dat      <= '0;
            r_pending  <= 1'b0;
            r_live     <= 1'b0;
            r_pend_vld <= 1'b0;
            r_pend_dat <= '0;
        end else begin
            r_live <= 1'b1;
            if (w_launch_ok && r_pend_vld) begin
                r_dat      <= r_pend_dat;
                r_req      <= ~r_req;
                r_pending  <= 1'b1;
                r_pend_vld <= 1'b0;
            end else if (w_accept && w_launch_ok) begin
                r_dat     <= dat_i;
                r_req     <= ~r_req;
                r_pending <= 1'b1;
            end else begin
                if (w_accept) begin
                    r_pend_vld <= 1'b1;
                    r_pend_dat <= dat_i;
                end
                if (w_done) begin
                    r_pending <= 1'b0;
                end
            end
        end
    end
`else
    assign ready_o = w_launch_ok && rst_n_i;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_req     <= 1'b0;
            r_dat     <= '0;
            r_pending <= 1'b0;
            r_live    <= 1'b0;
        end else begin
            r_live <= 1'b1;
            if (w_accept) begin
                r_dat     <= dat_i;
                r_req     <= ~r_req;
                r_pending <= 1'b1;
            end else if (w_done) begin
                r_pending <= 1'b0;
            end
        end
    end
`endif

    assign req_o  = r_req;
    assign dat_o  = r_dat;
    assign busy_o = (w_state == HS_BUSY);
    assign done_o = w_done;

endmodule

// File: tb/tb_cdc_hs_src.sv
// Directed self-checking bench for cdc_hs_src (STAGE = 2, DATA_WIDTH = 32).
// The destination side is driven by hand; ack_i toggles are placed explicitly.
module tb_cdc_hs_src;

    localparam int DW    = 32;
    localparam int STAGE = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          valid;
    logic [DW-1:0] din;
    logic          ready;
    logic          req;
    logic [DW-1:0] dout;
    logic          ack;
    logic          busy;
    logic          done;

    int   total     = 0;
    int   bad       = 0;
    int   done_seen = 0;
    int   done_base = 0;
    logic exp_req   = 1'b0;

    cdc_hs_src #(.DATA_WIDTH(DW), .STAGE(STAGE)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .valid_i (valid),
        .dat_i   (din),
        .ready_o (ready),
        .req_o   (req),
        .dat_o   (dout),
        .ack_i   (ack),
        .busy_o  (busy),
        .done_o  (done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done) done_seen++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        valid = 1'b0;
        ack   = 1'b0;
        din   = '0;
        tick();
        tick();
        check_bit("rst_ready", ready, 1'b0);
        check_bit("rst_req",   req,   1'b0);
        check    ("rst_dat",   dout,  32'h0);
        check_bit("rst_done",  done,  1'b0);

        rst_n = 1'b1;
        tick();
        check_bit("idle_ready", ready, 1'b1);
        check_bit("idle_busy",  busy,  1'b0);
        check_bit("idle_req",   req,   1'b0);
        check    ("idle_dat",   dout,  32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_bit("idle_no_done", done,  1'b0);
            check_bit("idle_ready_h", ready, 1'b1);
        end

        // Single transfer; ack returns 3 cycles after req rises.
        valid = 1'b1;
        din   = 32'hA5A5_0001;
        tick();
        valid   = 1'b0;
        din     = 32'h0;
        exp_req = ~exp_req;
        check_bit("single_req",   req,   exp_req);
        check    ("single_dat",   dout,  32'hA5A5_0001);
        check_bit("single_busy",  busy,  1'b1);
        check_bit("single_ready", ready, 1'b0);
        check_bit("single_done0", done,  1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check    ("single_dat_hold", dout, 32'hA5A5_0001);
            check_bit("single_no_done",  done, 1'b0);
        end
        ack = exp_req;
        tick();
        check_bit("single_done_early", done, 1'b0);
        check_bit("single_busy_sync",  busy, 1'b1);
        tick();
        check_bit("single_done",     done,  1'b1);
        check_bit("single_ready_up", ready, 1'b1);
        check_bit("single_idle",     busy,  1'b0);
        check    ("single_dat_done", dout,  32'hA5A5_0001);
        tick();
        check_bit("single_done_once", done, 1'b0);
        check    ("single_dat_after", dout, 32'hA5A5_0001);

`ifdef CDC_HS_SRC_BUF_EN
        // B0 launches, B1 parks in the buffer, then launches in B0's done cycle.
        valid = 1'b1;
        din   = 32'hB0;
        tick();
        exp_req = ~exp_req;
        check_bit("buf_req_b0", req,   exp_req);
        check    ("buf_dat_b0", dout,  32'hB0);
        check_bit("buf_ready",  ready, 1'b1);
        din = 32'hB1;
        tick();
        valid = 1'b0;
        din   = 32'h0;
        check_bit("buf_full_ready", ready, 1'b0);
        check    ("buf_dat_hold",   dout,  32'hB0);
        tick();
        ack = exp_req;
        tick();
        check_bit("buf_done_early", done, 1'b0);
        check    ("buf_dat_b0_2",   dout, 32'hB0);
        tick();
        check_bit("buf_done_b0",   done, 1'b1);
        check    ("buf_dat_b0_3",  dout, 32'hB0);
        tick();
        exp_req = ~exp_req;
        check    ("buf_dat_b1",    dout,  32'hB1);
        check_bit("buf_req_b1",    req,   exp_req);
        check_bit("buf_busy_b1",   busy,  1'b1);
        check_bit("buf_ready_b1",  ready, 1'b1);
        check_bit("buf_done_b1_0", done,  1'b0);
        ack = exp_req;
        tick();
        tick();
        check_bit("buf_done_b1", done, 1'b1);
        check    ("buf_dat_end", dout, 32'hB1);
`else
        // Back-to-back words with valid held high; later words wait for done.
        done_base = done_seen;
        valid     = 1'b1;
        din       = 32'h1;
        for (int w = 1; w <= 3; w++) begin
            tick();
            exp_req = ~exp_req;
            check_bit("b2b_req",  req,  exp_req);
            check    ("b2b_dat",  dout, DW'(w));
            check_bit("b2b_busy", busy, 1'b1);
            din = DW'(w + 1);
            for (int i = 0; i < 2; i++) begin
                tick();
                check    ("b2b_dat_hold",   dout,  DW'(w));
                check_bit("b2b_ready_busy", ready, 1'b0);
            end
            ack = exp_req;
            tick();
            check_bit("b2b_done_early", done, 1'b0);
            check    ("b2b_dat_sync",   dout, DW'(w));
            tick();
            check_bit("b2b_done",       done,  1'b1);
            check_bit("b2b_ready_done", ready, 1'b1);
            check    ("b2b_dat_done",   dout,  DW'(w));
        end
        valid = 1'b0;
        din   = 32'h0;
        tick();
        check    ("b2b_done_count", DW'(done_seen - done_base), 32'd3);
        check_bit("b2b_req_final",  req,  exp_req);
        check_bit("b2b_done_after", done, 1'b0);

        // Reset while busy, ack left stuck high: ready waits for ack to clear.
        valid = 1'b1;
        din   = 32'hC3;
        tick();
        valid   = 1'b0;
        din     = 32'h0;
        exp_req = ~exp_req;
        check_bit("rb_req",  req,  exp_req);
        check_bit("rb_busy", busy, 1'b1);
        ack   = 1'b1;
        rst_n = 1'b0;
        tick();
        check_bit("rb_req_clr",   req,   1'b0);
        check    ("rb_dat_clr",   dout,  32'h0);
        check_bit("rb_ready_rst", ready, 1'b0);
        tick();
        rst_n = 1'b1;
        check_bit("rb_ready_rel", ready, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_bit("rb_ready_stuck", ready, 1'b0);
            check_bit("rb_no_done",     done,  1'b0);
        end
        check_bit("rb_busy_stuck", busy, 1'b1);
        ack = 1'b0;
        tick();
        check_bit("rb_ready_sync", ready, 1'b0);
        tick();
        check_bit("rb_ready_up",  ready, 1'b1);
        check_bit("rb_done_none", done,  1'b0);
        check_bit("rb_req_zero",  req,   1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cdc_hs_src.md
Name: cdc_hs_src

Overview:
- Source-side (launching) end of a two-phase toggle request/acknowledge clock-domain-crossing handshake.
- Runs entirely in the source clock domain.
- Accepts words over a valid/ready interface, holds each word stable on dat_o and toggles req_o.
- Waits for the destination's echoed toggle on ack_i, synchronised internally, before launching the next word.
- Pairs with a destination block that synchronises req_o, captures dat_o and toggles ack_i back.

Parameters:
DATA_WIDTH, 32, width of the transferred word
STAGE, 2, flop stages in the ack_i synchroniser; legal range 2..4

Ports:
clk_i  input  1  source-domain clock
rst_n_i  input  1  reset; one clock; reset is synchronous and active-low
valid_i  input  1  source word valid
dat_i  input  DATA_WIDTH  source word
ready_o  output  1  block can accept a word this cycle
req_o  output  1  toggle request to destination, registered
dat_o  output  DATA_WIDTH  held data to destination, registered
ack_i  input  1  toggle acknowledge from destination, asynchronous
busy_o  output  1  a transfer is outstanding (req_o != synced ack)
done_o  output  1  one-cycle pulse when a transfer's ack is observed

Behaviour:
- Synchronous reset, sampled on the rising edge of clk_i.
  - Reset clears req_o, dat_o, the ack synchroniser, done_o and the pending state to 0.
  - ready_o is forced 0 while rst_n_i is low.
- ack_s is the STAGE-flop synchronised copy of ack_i.
- States:
  - IDLE: ack_s == req_o.
  - BUSY: ack_s != req_o.
  - busy_o = BUSY, combinational from registered signals.
- ready_o (buffer feature off) = IDLE && rst_n_i.
  - After reset with ack_i stuck at 1, ready_o stays low until ack_s returns to 0.
  - This guards against a destination that was not reset together with the source.
- Accept on a rising edge with valid_i && ready_o:
  - dat_o <= dat_i.
  - req_o <= ~req_o.
  - The state is BUSY from the next cycle.
  - Latency is 1 cycle from accept to the req_o toggle.
- dat_o changes only on a launch; it is stable for the whole BUSY period.
- BUSY -> IDLE when ack_s == req_o.
  - done_o pulses high for exactly 1 cycle: the first cycle in which ack_s matches req_o after a launch.
  - ready_o rises in that same cycle.
- Minimum round trip: 1 launch cycle + destination sync latency + STAGE cycles.
- valid_i held with ready_o low: no state change; dat_i ignored.
- Any ack_i change while IDLE, other than the post-reset mismatch case, is treated as a protocol error: the block enters BUSY and waits for the match.
- Reset mid-transfer: the transfer is abandoned and req_o returns to 0. The ready_o guard above applies until ack_s == 0.

Optional Feature:
- Macro CDC_HS_SRC_BUF_EN.
- Defined:
  - Adds a one-entry pending buffer (pend_vld, pend_dat) and ready_o = !pend_vld && rst_n_i.
  - An accept in IDLE launches directly.
  - An accept in BUSY stores into the pending buffer.
  - In the done cycle with pend_vld set: dat_o <= pend_dat, req_o toggles, pend_vld clears. There is no idle bubble.
  - An accept in the done cycle with the buffer empty launches directly.
- Not defined: no buffer; ready_o as described above; the pending logic is absent from the netlist.

Decomposition:
- Shared package: cdc_hs_pkg, holding:
  - typedef enum {HS_IDLE, HS_BUSY} hs_state_e;
  - constant HS_STAGE_MIN = 2.
  - The destination block reuses the same package.
- Sub-module: cdc_hs_ack_sync, a single-bit, STAGE-deep, synchronous-reset flop chain producing ack_s.

Test Plan:
- Reset, then hold valid_i=0 and ack_i=0 -> ready_o=1, req_o=0, dat_o=0, busy_o=0, done_o never pulses.
- Single transfer: valid_i=1, dat_i=32'hA5A5_0001 for one accept; the bench toggles ack_i 3 cycles after req_o rises -> dat_o=32'hA5A5_0001 stable throughout; done_o pulses exactly STAGE cycles after the ack_i edge; ready_o returns to 1.
- Back-to-back words 32'h1, 32'h2, 32'h3 with valid_i held high -> req_o toggles three times; dat_o shows each value only while its request is outstanding; exactly 3 done_o pulses.
- Reset asserted while BUSY with ack_i=1 left stuck -> req_o=0 after reset; ready_o stays 0 until ack_i is driven 0 and STAGE cycles elapse.
- valid_i high while BUSY (no buffer) -> ready_o=0; dat_o unchanged; the word is accepted only after done_o.
- With CDC_HS_SRC_BUF_EN, send 32'hB0 then 32'hB1 while BUSY -> 32'hB1 is accepted into the pending buffer and ready_o drops; in the done cycle of 32'hB0, dat_o=32'hB1 and req_o toggles again with no idle cycle.
